// File: rtl/pipe_ctrl_defs_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and the debug/trace unit:
// FSM state encodings and the default mul/div timeout.
package pipe_ctrl_defs_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MD_WAIT   = 2'd1,
        ST_MEM_WAIT  = 2'd2,
        ST_EXC_DRAIN = 2'd3
    } pipe_state_e;

    localparam int unsigned MD_TIMEOUT_DEF = 64;
    localparam int unsigned DRAIN_W        = 3;
    localparam int unsigned PERF_W         = 32;

endpackage

// File: rtl/stall_perf_cnt.sv
// Saturating stall-event counter; increments once per cycle while i_inc is high.
module stall_perf_cnt
    import pipe_ctrl_defs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    output logic [PERF_W-1:0] o_cnt
);

    logic [PERF_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {PERF_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional stall performance counters are built when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl
    import pipe_ctrl_defs_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT    = MD_TIMEOUT_DEF,
    parameter int unsigned EXC_DRAIN_CYC = 2,
    parameter int unsigned DELAY_SLOT    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_use,
    input  logic       md_start_ex,
    input  logic       md_done,
    input  logic       mem_ready,
    input  logic       mem_access,
    input  logic       branch_taken,
    input  logic       exc_req_mem,
    input  logic       eret_mem,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       stall_mem,
    output logic       bubble_ex,
    output logic       bubble_wb,
    output logic       flush_id,
    output logic       flush_ex,
    output logic       flush_mem,
    output logic       pc_sel_exc,
    output logic       md_timeout_err,
    output logic [1:0] busy_state
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] perf_load_stall,
    output logic [31:0] perf_md_stall,
    output logic [31:0] perf_mem_stall
`endif
);

    localparam int unsigned MD_CW = $clog2(MD_TIMEOUT + 1);

    pipe_state_e        r_state;
    pipe_state_e        w_state_nxt;
    logic [MD_CW-1:0]   r_md_cnt;
    logic [MD_CW-1:0]   w_md_cnt_nxt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [DRAIN_W-1:0] w_drain_cnt_nxt;
    logic               r_md_err;
    logic               w_md_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_md_cnt    <= '0;
            r_drain_cnt <= '0;
            r_md_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_md_cnt    <= w_md_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_md_err    <= w_md_err_nxt;
        end
    end

    // Outputs are decoded from current state and inputs; all forced low during reset.
    always_comb begin
        stall_if        = 1'b0;
        stall_id        = 1'b0;
        stall_ex        = 1'b0;
        stall_mem       = 1'b0;
        bubble_ex       = 1'b0;
        bubble_wb       = 1'b0;
        flush_id        = 1'b0;
        flush_ex        = 1'b0;
        flush_mem       = 1'b0;
        pc_sel_exc      = 1'b0;
        w_state_nxt     = r_state;
        w_md_cnt_nxt    = r_md_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_md_err_nxt    = r_md_err;

        if (!rst_n) begin
            w_state_nxt = ST_RUN;
        end else if (exc_req_mem || eret_mem) begin
            flush_id        = 1'b1;
            flush_ex        = 1'b1;
            flush_mem       = 1'b1;
            pc_sel_exc      = 1'b1;
            w_state_nxt     = ST_EXC_DRAIN;
            w_drain_cnt_nxt = DRAIN_W'(EXC_DRAIN_CYC - 1);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_access && !mem_ready) begin
                        stall_if    = 1'b1;
                        stall_id    = 1'b1;
                        stall_ex    = 1'b1;
                        stall_mem   = 1'b1;
                        bubble_wb   = 1'b1;
                        w_state_nxt = ST_MEM_WAIT;
                    end else if (md_start_ex) begin
                        // A result already valid at issue needs no wait.
                        if (!md_done) begin
                            stall_if     = 1'b1;
                            stall_id     = 1'b1;
                            w_md_cnt_nxt = '0;
                            w_state_nxt  = ST_MD_WAIT;
                        end
                    end else if (load_use) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (branch_taken && (DELAY_SLOT == 0)) begin
                        flush_id = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    if (md_done) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                        if (r_md_cnt == MD_CW'(MD_TIMEOUT - 1)) begin
                            w_md_err_nxt = 1'b1;
                            w_state_nxt  = ST_RUN;
                        end else begin
                            w_md_cnt_nxt = r_md_cnt + 1'b1;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                        bubble_wb = 1'b1;
                    end
                end
                ST_EXC_DRAIN: begin
                    flush_id = 1'b1;
                    if (r_drain_cnt == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt - 1'b1;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign md_timeout_err = r_md_err;
    assign busy_state     = r_state;

`ifdef STALL_PERF_CNT_EN
    // Each stall source has a unique output signature: bubble_ex only for load-use,
    // bubble_wb only for memory wait, a bare front-end stall otherwise for mul/div.
    logic w_load_stall;
    logic w_md_stall;
    logic w_mem_stall;

    assign w_load_stall = bubble_ex;
    assign w_mem_stall  = bubble_wb;
    assign w_md_stall   = stall_if && !bubble_ex && !bubble_wb;

    stall_perf_cnt u_perf_load (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_load_stall),
        .o_cnt (perf_load_stall)
    );

    stall_perf_cnt u_perf_md (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_md_stall),
        .o_cnt (perf_md_stall)
    );

    stall_perf_cnt u_perf_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_mem_stall),
        .o_cnt (perf_mem_stall)
    );
`endif

endmodule
